// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter: FSM state
// encoding and the counter width helper.
package piso_pkg;

  // Two-state controller: nothing loaded, or a word is being shifted out.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Bits needed to hold the values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Mod-WIDTH bit index counter for the serializer. Tracks which bit of the
// current word is on the serial output and flags the last one.
module bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,     // synchronous, active-low
  input  logic i_clr,   // return to zero when the shifter goes idle
  input  logic i_load,  // restart at bit 0 when a new word is loaded
  input  logic i_inc,   // advance to the next bit
  output logic o_tc     // current bit is the last bit of the word
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;

  // Bit index register; saturates at the last index so it only wraps on a load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr || i_load) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc && (r_cnt != LAST_IDX)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter. Takes a word over valid/ready and emits
// it one bit per clock on sout, qualified by sout_valid. A new word can be
// accepted on the cycle carrying the last bit, so streams have no bubbles.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam bit MSB_OUT = (MSB_FIRST != 0);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             r_sout;
  logic             w_sout_nxt;
  logic             r_sout_valid;
  logic             w_sout_valid_nxt;

  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_load;
  logic             w_cnt_inc;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_load (w_cnt_load),
    .i_inc  (w_cnt_inc),
    .o_tc   (w_tc)
  );

  // Ready when idle or on the last bit; gated by reset so nothing is taken then.
  assign in_ready = rst && ((r_state == S_IDLE) || ((r_state == S_SHIFT) && w_tc));
  assign w_accept = in_valid && in_ready;

  // Bit order selection: which end of the word leaves first.
  assign w_first_bit = MSB_OUT ? in_data[WIDTH-1] : in_data[0];
  assign w_next_bit  = MSB_OUT ? r_shreg[WIDTH-2] : r_shreg[1];
  assign w_shifted   = MSB_OUT ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

  // Next-state and datapath decisions; everything holds unless a case says otherwise.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_sout_nxt       = r_sout;
    w_sout_valid_nxt = r_sout_valid;
    w_cnt_clr        = 1'b0;
    w_cnt_load       = 1'b0;
    w_cnt_inc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt      = S_SHIFT;
          w_shreg_nxt      = in_data;
          w_sout_nxt       = w_first_bit;
          w_sout_valid_nxt = 1'b1;
          w_cnt_load       = 1'b1;
        end else begin
          w_sout_nxt       = 1'b0;
          w_sout_valid_nxt = 1'b0;
        end
      end
      S_SHIFT: begin
        if (!w_tc) begin
          w_shreg_nxt = w_shifted;
          w_sout_nxt  = w_next_bit;
          w_cnt_inc   = 1'b1;
        end else if (w_accept) begin
          // Back-to-back word: reload straight from the last bit, no idle gap.
          w_state_nxt      = S_SHIFT;
          w_shreg_nxt      = in_data;
          w_sout_nxt       = w_first_bit;
          w_sout_valid_nxt = 1'b1;
          w_cnt_load       = 1'b1;
        end else begin
          w_state_nxt      = S_IDLE;
          w_sout_nxt       = 1'b0;
          w_sout_valid_nxt = 1'b0;
          w_cnt_clr        = 1'b1;
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_sout_nxt       = 1'b0;
        w_sout_valid_nxt = 1'b0;
        w_cnt_clr        = 1'b1;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shreg      <= {WIDTH{1'b0}};
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
    end else begin
      r_shreg      <= w_shreg_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = (r_state == S_SHIFT);
  assign done       = (r_state == S_SHIFT) && w_tc;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// share the same stimulus; a sipo model rebuilds words from the MSB-first stream.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;

  logic m_ready, m_sout, m_sv, m_busy, m_done;
  logic l_ready, l_sout, l_sv, l_busy, l_done;

  logic [3:0] sipo_q;
  logic [7:0] seq8;
  logic [7:0] dn8;
  logic [3:0] seq4;
  logic [3:0] alt4;

  int n_checks;
  int n_pass;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_ready), .in_data(in_data),
    .sout(m_sout), .sout_valid(m_sv), .busy(m_busy), .done(m_done)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_ready), .in_data(in_data),
    .sout(l_sout), .sout_valid(l_sv), .busy(l_busy), .done(l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream sipo: left-shift fill from the MSB-first stream.
  always @(posedge clk) begin
    if (!rst) sipo_q <= 4'h0;
    else if (m_sv) sipo_q <= {sipo_q[2:0], m_sout};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks on the MSB-first instance for one cycle.
  task automatic chk_m(input string tag, input logic s, input logic v, input logic d, input logic r);
    chk({tag, ".sout"},  {31'd0, m_sout},  {31'd0, s});
    chk({tag, ".valid"}, {31'd0, m_sv},    {31'd0, v});
    chk({tag, ".done"},  {31'd0, m_done},  {31'd0, d});
    chk({tag, ".ready"}, {31'd0, m_ready}, {31'd0, r});
    chk({tag, ".busy"},  {31'd0, m_busy},  {31'd0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;

    // 1. reset
    step();
    step();
    chk_m("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.l_sv",   {31'd0, l_sv},   32'd0);
    chk("rst.l_busy", {31'd0, l_busy}, 32'd0);
    chk("rst.l_done", {31'd0, l_done}, 32'd0);
    rst = 1'b1;
    #1;
    chk_m("rel", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rel.l_ready", {31'd0, l_ready}, 32'd1);

    // 2. single word 1101, MSB first
    seq4 = 4'b1101;
    in_data  = 4'hD;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_m($sformatf("w1101[%0d]", k), seq4[3-k], 1'b1, (k == 3), (k == 3));
      if (k == 0) in_valid = 1'b0;
    end
    step();
    chk_m("w1101.end", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("w1101.sipo", {28'd0, sipo_q}, 32'hD);

    // 3. back-to-back A then 5
    seq8 = 8'b10100101;
    dn8  = 8'b00010001;
    in_data  = 4'hA;
    in_valid = 1'b1;
    #1;
    chk("b2b.ready0", {31'd0, m_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_m($sformatf("b2b[%0d]", k), seq8[7-k], 1'b1, dn8[7-k], dn8[7-k]);
      if (k == 0) in_data = 4'h5;
      if (k == 4) begin
        in_valid = 1'b0;
        chk("b2b.sipoA", {28'd0, sipo_q}, 32'hA);
      end
    end
    step();
    chk_m("b2b.end", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b.sipo5", {28'd0, sipo_q}, 32'h5);

    // 4. F offered mid-word is held off until the last bit
    seq8 = 8'b00001111;
    in_data  = 4'h0;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_m($sformatf("hold[%0d]", k), seq8[7-k], 1'b1, dn8[7-k], dn8[7-k]);
      if (k == 0) in_valid = 1'b0;
      if (k == 1) begin
        in_valid = 1'b1;
        in_data  = 4'hF;
      end
      if (k == 4) in_valid = 1'b0;
    end
    step();
    chk_m("hold.end", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold.sipo", {28'd0, sipo_q}, 32'hF);

    // 5. reset while sending 9 at cnt=2, then a clean word 6
    seq4 = 4'b1001;
    in_data  = 4'h9;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_m($sformatf("abort[%0d]", k), seq4[3-k], 1'b1, 1'b0, 1'b0);
      if (k == 0) in_valid = 1'b0;
    end
    rst = 1'b0;
    step();
    chk_m("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    seq4 = 4'b0110;
    in_data  = 4'h6;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_m($sformatf("after[%0d]", k), seq4[3-k], 1'b1, (k == 3), (k == 3));
      if (k == 0) in_valid = 1'b0;
    end
    step();
    chk("after.sipo", {28'd0, sipo_q}, 32'h6);

    // 6. LSB-first instance, word 0011
    seq4 = 4'b1100;
    alt4 = 4'b0011;
    in_data  = 4'b0011;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("lsb[%0d].sout", k),  {31'd0, l_sout}, {31'd0, seq4[3-k]});
      chk($sformatf("lsb[%0d].valid", k), {31'd0, l_sv},   32'd1);
      chk($sformatf("lsb[%0d].done", k),  {31'd0, l_done}, {31'd0, (k == 3)});
      chk($sformatf("msb[%0d].sout", k),  {31'd0, m_sout}, {31'd0, alt4[3-k]});
      if (k == 0) in_valid = 1'b0;
    end
    step();
    chk("lsb.end.valid", {31'd0, l_sv},   32'd0);
    chk("lsb.end.sout",  {31'd0, l_sout}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
